// File: rtl/hazard_forward_controller.sv
// hazard_forward_controller: execute-stage forwarding selects, load-use and MULT/DIV hazard stalls
//   clk, reset_n              : clock, asynchronous active-low reset
//   *_decode                  : decode-stage sources and HI/LO / MULT-DIV flags
//   *_execute (inputs)        : execute-stage sources, destination, load flag, MULT/DIV issue
//   *_memory, *_writeback     : downstream GPR and HI/LO write info
//   forward_one/two_execute   : operand A/B source select
//   stall_fetch/decode, flush_execute : combined hazard stall and bubble
//   muldiv_busy               : MULT/DIV unit in progress
module hazard_forward_controller #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs_decode,
    input  logic [4:0] rt_decode,
    input  logic       hi_lo_read_decode,
    input  logic       muldiv_decode,
    input  logic [4:0] rs_execute,
    input  logic [4:0] rt_execute,
    input  logic       uses_lo_execute,
    input  logic       uses_hi_execute,
    input  logic [4:0] write_reg_execute,
    input  logic       reg_write_execute,
    input  logic       memory_to_register_execute,
    input  logic       muldiv_start_execute,
    input  logic [4:0] write_reg_memory,
    input  logic       reg_write_memory,
    input  logic       hi_lo_write_memory,
    input  logic [4:0] write_reg_writeback,
    input  logic       reg_write_writeback,
    input  logic       hi_lo_write_writeback,
    output logic [2:0] forward_one_execute,
    output logic [2:0] forward_two_execute,
    output logic       stall_fetch,
    output logic       stall_decode,
    output logic       flush_execute,
    output logic       muldiv_busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    logic [0:0] state;
    logic [5:0] count;
    logic [2:0] hi_lo_code;
    logic mem_rs, mem_rt, wb_rs, wb_rt, load_use, hi_lo_stall, unused_ok;
    // reg_write_execute is implied by a load and not needed for hazard detection
    assign unused_ok = reg_write_execute;
    always_comb begin
        hi_lo_code = hi_lo_write_memory ? 3'b100 : hi_lo_write_writeback ? 3'b011 : 3'b000;
        mem_rs = reg_write_memory && write_reg_memory != 5'd0 && write_reg_memory == rs_execute;
        mem_rt = reg_write_memory && write_reg_memory != 5'd0 && write_reg_memory == rt_execute;
        wb_rs = reg_write_writeback && write_reg_writeback != 5'd0 && write_reg_writeback == rs_execute;
        wb_rt = reg_write_writeback && write_reg_writeback != 5'd0 && write_reg_writeback == rt_execute;
        forward_one_execute = uses_lo_execute ? hi_lo_code : mem_rs ? 3'b010 : wb_rs ? 3'b001 : 3'b000;
        forward_two_execute = uses_hi_execute ? hi_lo_code : mem_rt ? 3'b010 : wb_rt ? 3'b001 : 3'b000;
        load_use = memory_to_register_execute && write_reg_execute != 5'd0 &&
                   (write_reg_execute == rs_decode || write_reg_execute == rt_decode);
        // the issue cycle already blocks HI/LO readers and a second MULT/DIV
        hi_lo_stall = (muldiv_busy || muldiv_start_execute) && (hi_lo_read_decode || muldiv_decode);
        stall_fetch = load_use || hi_lo_stall;
        stall_decode = stall_fetch;
        flush_execute = stall_fetch;
    end
    assign muldiv_busy = state == BUSY;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= 6'd0;
        end else if (state == IDLE) begin
            if (muldiv_start_execute) begin
                state <= BUSY;
                count <= 6'(MULDIV_CYCLES - 1);
            end
        end else if (count != 6'd0) begin
            count <= count - 6'd1;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_hazard_forward_controller.sv
// tb_hazard_forward_controller: vector, sequence and randomized model checks of hazard_forward_controller
module tb_hazard_forward_controller;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute, write_reg_execute;
    logic [4:0] write_reg_memory, write_reg_writeback;
    logic hi_lo_read_decode, muldiv_decode, uses_lo_execute, uses_hi_execute;
    logic reg_write_execute, memory_to_register_execute, muldiv_start_execute;
    logic reg_write_memory, hi_lo_write_memory, reg_write_writeback, hi_lo_write_writeback;
    logic [2:0] forward_one_execute, forward_two_execute;
    logic stall_fetch, stall_decode, flush_execute, muldiv_busy;
    int n_checks = 0;
    int n_fail = 0;
    int busy_left = 0;

    hazard_forward_controller #(.MULDIV_CYCLES(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_decode(rs_decode), .rt_decode(rt_decode),
        .hi_lo_read_decode(hi_lo_read_decode), .muldiv_decode(muldiv_decode),
        .rs_execute(rs_execute), .rt_execute(rt_execute),
        .uses_lo_execute(uses_lo_execute), .uses_hi_execute(uses_hi_execute),
        .write_reg_execute(write_reg_execute), .reg_write_execute(reg_write_execute),
        .memory_to_register_execute(memory_to_register_execute),
        .muldiv_start_execute(muldiv_start_execute),
        .write_reg_memory(write_reg_memory), .reg_write_memory(reg_write_memory),
        .hi_lo_write_memory(hi_lo_write_memory),
        .write_reg_writeback(write_reg_writeback), .reg_write_writeback(reg_write_writeback),
        .hi_lo_write_writeback(hi_lo_write_writeback),
        .forward_one_execute(forward_one_execute), .forward_two_execute(forward_two_execute),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_execute(flush_execute), .muldiv_busy(muldiv_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs_e, rt_e, wm, rwm, hlm, ww, rww, hlw, ulo, uhi, wx, m2r, rs_d, rt_d;
        int fa, fb, st;
    } vec_t;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        chk({name, ".stall_fetch"}, {2'b0, stall_fetch}, {2'b0, exp});
        chk({name, ".stall_decode"}, {2'b0, stall_decode}, {2'b0, exp});
        chk({name, ".flush_execute"}, {2'b0, flush_execute}, {2'b0, exp});
    endtask

    task automatic clear_inputs();
        rs_decode = 0; rt_decode = 0; rs_execute = 0; rt_execute = 0; write_reg_execute = 0;
        write_reg_memory = 0; write_reg_writeback = 0;
        hi_lo_read_decode = 0; muldiv_decode = 0; uses_lo_execute = 0; uses_hi_execute = 0;
        reg_write_execute = 0; memory_to_register_execute = 0; muldiv_start_execute = 0;
        reg_write_memory = 0; hi_lo_write_memory = 0; reg_write_writeback = 0;
        hi_lo_write_writeback = 0;
    endtask

    function automatic logic [2:0] ref_fwd(input logic hl_use, input logic [4:0] src);
        if (hl_use) return hi_lo_write_memory ? 3'd4 : hi_lo_write_writeback ? 3'd3 : 3'd0;
        if (reg_write_memory && write_reg_memory != 0 && write_reg_memory == src) return 3'd2;
        if (reg_write_writeback && write_reg_writeback != 0 && write_reg_writeback == src) return 3'd1;
        return 3'd0;
    endfunction

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{5, 0, 5, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
        vecs[1]  = '{5, 0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[2]  = '{3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{7, 7, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0, 1, 3, 0};
        vecs[4]  = '{7, 7, 7, 1, 1, 7, 1, 1, 0, 1, 0, 0, 0, 0, 2, 4, 0};
        vecs[5]  = '{7, 9, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0};
        vecs[6]  = '{7, 9, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 3, 8, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 8, 3, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 8, 8, 0, 0, 0};
        clear_inputs();
        hi_lo_read_decode = 1;
        #12;
        chk("reset.busy", {2'b0, muldiv_busy}, 3'd0);
        chk_stall("reset", 1'b0);
        @(negedge clk);
        reset_n = 1;
        // combinational vectors with the MULT/DIV unit idle
        foreach (vecs[i]) begin
            @(negedge clk);
            clear_inputs();
            rs_execute = 5'(vecs[i].rs_e); rt_execute = 5'(vecs[i].rt_e);
            write_reg_memory = 5'(vecs[i].wm); reg_write_memory = vecs[i].rwm[0];
            hi_lo_write_memory = vecs[i].hlm[0];
            write_reg_writeback = 5'(vecs[i].ww); reg_write_writeback = vecs[i].rww[0];
            hi_lo_write_writeback = vecs[i].hlw[0];
            uses_lo_execute = vecs[i].ulo[0]; uses_hi_execute = vecs[i].uhi[0];
            write_reg_execute = 5'(vecs[i].wx); memory_to_register_execute = vecs[i].m2r[0];
            reg_write_execute = vecs[i].m2r[0];
            rs_decode = 5'(vecs[i].rs_d); rt_decode = 5'(vecs[i].rt_d);
            #1;
            chk($sformatf("vec%0d.fwd_a", i), forward_one_execute, 3'(vecs[i].fa));
            chk($sformatf("vec%0d.fwd_b", i), forward_two_execute, 3'(vecs[i].fb));
            chk_stall($sformatf("vec%0d", i), vecs[i].st[0]);
        end
        // load-use: stall while the load is in execute, released once it reaches memory
        @(negedge clk);
        clear_inputs();
        write_reg_execute = 8; memory_to_register_execute = 1; reg_write_execute = 1; rt_decode = 8;
        #1 chk_stall("loaduse.c0", 1'b1);
        @(negedge clk);
        write_reg_execute = 0; memory_to_register_execute = 0; reg_write_execute = 0;
        write_reg_memory = 8; reg_write_memory = 1;
        #1 chk_stall("loaduse.c1", 1'b0);
        // MULT/DIV issue with MFLO waiting in decode
        @(negedge clk);
        clear_inputs();
        muldiv_start_execute = 1; hi_lo_read_decode = 1;
        #1;
        chk("md.issue.busy", {2'b0, muldiv_busy}, 3'd0);
        chk_stall("md.issue", 1'b1);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            muldiv_start_execute = 0;
            #1;
            chk($sformatf("md.busy%0d", c), {2'b0, muldiv_busy}, 3'd1);
            chk_stall($sformatf("md.busy%0d", c), 1'b1);
        end
        @(negedge clk);
        #1;
        chk("md.done.busy", {2'b0, muldiv_busy}, 3'd0);
        chk_stall("md.done", 1'b0);
        // reset two cycles into BUSY aborts it with no restart
        @(negedge clk);
        muldiv_start_execute = 1;
        @(negedge clk);
        muldiv_start_execute = 0;
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("rst.busy", {2'b0, muldiv_busy}, 3'd0);
        chk_stall("rst", 1'b0);
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < N + 1; c++) begin
            @(negedge clk);
            #1 chk($sformatf("rst.idle%0d", c), {2'b0, muldiv_busy}, 3'd0);
        end
        // randomized run against a cycle-count model of the MULT/DIV unit
        busy_left = 0;
        for (int it = 0; it < 400; it++) begin
            logic lu, hl;
            @(negedge clk);
            rs_decode = 5'($urandom_range(0, 3)); rt_decode = 5'($urandom_range(0, 3));
            rs_execute = 5'($urandom_range(0, 3)); rt_execute = 5'($urandom_range(0, 3));
            write_reg_execute = 5'($urandom_range(0, 3));
            write_reg_memory = 5'($urandom_range(0, 3));
            write_reg_writeback = 5'($urandom_range(0, 3));
            hi_lo_read_decode = ($urandom_range(0, 2) == 0);
            muldiv_decode = ($urandom_range(0, 5) == 0);
            uses_lo_execute = ($urandom_range(0, 3) == 0);
            uses_hi_execute = ($urandom_range(0, 3) == 0);
            memory_to_register_execute = ($urandom_range(0, 2) == 0);
            reg_write_execute = memory_to_register_execute | 1'($urandom_range(0, 1));
            muldiv_start_execute = ($urandom_range(0, 5) == 0);
            reg_write_memory = 1'($urandom_range(0, 1));
            hi_lo_write_memory = ($urandom_range(0, 3) == 0);
            reg_write_writeback = 1'($urandom_range(0, 1));
            hi_lo_write_writeback = ($urandom_range(0, 3) == 0);
            #1;
            lu = memory_to_register_execute && write_reg_execute != 0 &&
                 (write_reg_execute == rs_decode || write_reg_execute == rt_decode);
            hl = (busy_left > 0 || muldiv_start_execute) && (hi_lo_read_decode || muldiv_decode);
            chk("rnd.fwd_a", forward_one_execute, ref_fwd(uses_lo_execute, rs_execute));
            chk("rnd.fwd_b", forward_two_execute, ref_fwd(uses_hi_execute, rt_execute));
            chk("rnd.busy", {2'b0, muldiv_busy}, {2'b0, busy_left > 0});
            chk_stall("rnd", lu || hl);
            @(posedge clk);
            if (busy_left == 0 && muldiv_start_execute) busy_left = N;
            else if (busy_left > 0) busy_left--;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_forward_controller.md
# hazard_forward_controller

Pipeline hazard controller for the 5-stage MIPS core. It drives the execute-stage operand forwarding selects (`forward_one_execute`, `forward_two_execute`) and detects load-use hazards. It also sequences the multi-cycle MULT/DIV unit through a busy FSM/counter. From these it generates stall and flush controls for fetch, decode and execute. It sits beside the pipeline registers and takes only register indices and write-enable flags, no data.

## Interface
- `MULDIV_CYCLES`, default 32: cycles the MULT/DIV unit needs after issue; legal range 2..63.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `rs_decode`, `rt_decode` input 5 each: source registers of the instruction in decode.
- `hi_lo_read_decode` input 1: decode instruction is MFHI/MFLO.
- `muldiv_decode` input 1: decode instruction is MULT/MULTU/DIV/DIVU.
- `rs_execute`, `rt_execute` input 5 each: source registers in execute.
- `uses_lo_execute`, `uses_hi_execute` input 1 each: execute reads LO via operand A / HI via operand B.
- `write_reg_execute` input 5: execute destination register.
- `reg_write_execute`, `memory_to_register_execute` input 1 each: execute writes a GPR / is a load.
- `muldiv_start_execute` input 1: MULT/DIV issuing in execute this cycle.
- `write_reg_memory`, `reg_write_memory`, `hi_lo_write_memory` input 5/1/1: memory-stage write info.
- `write_reg_writeback`, `reg_write_writeback`, `hi_lo_write_writeback` input 5/1/1: writeback-stage write info.
- `forward_one_execute` output 3: operand-A source select.
- `forward_two_execute` output 3: operand-B source select.
- `stall_fetch`, `stall_decode` output 1 each: hold the PC / hold the IF/ID register.
- `flush_execute` output 1: insert a bubble into ID/EX.
- `muldiv_busy` output 1: MULT/DIV in progress.

## Operation
- **Forward select A** (first match wins; register 0 never matches):
  - `uses_lo_execute` and `hi_lo_write_memory` -> 3'b100
  - `uses_lo_execute` and `hi_lo_write_writeback` -> 3'b011
  - `uses_lo_execute` otherwise -> 3'b000
  - `reg_write_memory` and `write_reg_memory == rs_execute` -> 3'b010
  - `reg_write_writeback` and `write_reg_writeback == rs_execute` -> 3'b001
  - otherwise 3'b000
- **Forward select B**: same priority, using `rt_execute`, `uses_hi_execute` and HI codes 3'b100 (memory) / 3'b011 (writeback).
- Codes 3'b101-3'b111 are never produced.
- **Load-use stall**: asserted when `memory_to_register_execute && write_reg_execute != 0` and `write_reg_execute` equals `rs_decode` or `rt_decode`.
- **MULT/DIV FSM**, states IDLE and BUSY, with a 6-bit down-counter.
  - IDLE, `muldiv_start_execute` -> BUSY; counter loads `MULDIV_CYCLES-1`.
  - BUSY, counter != 0 -> decrement.
  - BUSY, counter == 0 -> IDLE.
  - `muldiv_start_execute` while BUSY is ignored: no reload, no state change.
- `muldiv_busy` = (state == BUSY).
- **HI/LO stall**: `muldiv_busy && (hi_lo_read_decode || muldiv_decode)`.
  - It is also asserted in the issue cycle (`muldiv_start_execute` with the decode instruction reading HI/LO or another MULT/DIV).
- **Outputs**: `stall_fetch = stall_decode = flush_execute` = load-use stall OR HI/LO stall.
- A flush does not cancel a MULT/DIV already started.

## Timing
- Forward selects and stall/flush outputs are combinational from current inputs and FSM state; there is no added latency.
- The FSM and counter update on the rising `clk` edge.
- `muldiv_busy` is high for exactly `MULDIV_CYCLES` cycles, starting the cycle after the edge that samples `muldiv_start_execute`.
- A dependent MFHI held in decode leaves decode in the first cycle `muldiv_busy` is low.
- **Reset** (asynchronous, `reset_n` low): state = IDLE, counter = 0, `muldiv_busy` = 0. Stalls then depend only on the load-use term.
- Reset mid-operation aborts BUSY immediately. There is no restart after release.
- **Simultaneous events**:
  - Load-use and HI/LO stall together give one stall; all three stall/flush outputs stay asserted.
  - The BUSY->IDLE transition and a new `muldiv_start_execute` on the same edge go to IDLE; the start is ignored. The HI/LO stall prevents this by construction.

## Test plan
- **Forward priority**: `rs_execute`=5; memory writes r5; writeback writes r5 -> `forward_one_execute`=3'b010. Drop the memory write -> 3'b001.
- **Register zero**: `rt_execute`=0; memory writes r0 -> `forward_two_execute`=3'b000.
- **HI/LO forward**: `uses_hi_execute`=1, `hi_lo_write_writeback`=1 -> `forward_two_execute`=3'b011. Add `hi_lo_write_memory`=1 -> 3'b100.
- **Load-use**: load to r8 in execute, `rt_decode`=8 -> stall/flush high for 1 cycle; low the next cycle once the load has moved to memory.
- **MULT/DIV**: `MULDIV_CYCLES`=4, start pulse, MFLO in decode -> `muldiv_busy` high for exactly 4 cycles and stall high throughout. Stall drops in the cycle `muldiv_busy` falls.
- **Reset mid-BUSY**: drop `reset_n` 2 cycles into BUSY -> `muldiv_busy`=0 immediately and stall released. After release it stays IDLE.
